// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_pkg
// Description : Shared BCD constants, run-state enum and digit clamp helper
//               for the BCD stopwatch core.
// Revision    : 1.0  initial release
// ============================================================================
package stopwatch_pkg;

    localparam int         BCD_W   = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [0:0] {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } sw_state_t;

    function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_cell.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_cell
// Description : One BCD digit of the ripple counter: increment/decrement with
//               carry/borrow chaining and max/zero flags.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_digit_cell
    import stopwatch_pkg::*;
(
    input  logic [BCD_W-1:0] i_digit,
    input  logic             i_enable,
    input  logic             i_down,
    input  logic             i_cin,
    output logic [BCD_W-1:0] o_next,
    output logic             o_cout,
    output logic             o_is_max,
    output logic             o_is_zero
);

    logic w_step;

    assign w_step    = i_enable & i_cin;
    assign o_is_max  = (i_digit == BCD_MAX);
    assign o_is_zero = (i_digit == '0);

    always_comb begin
        o_next = i_digit;
        o_cout = 1'b0;
        if (w_step) begin
            if (i_down) begin
                o_cout = o_is_zero;
                o_next = o_is_zero ? BCD_MAX : (i_digit - 1'b1);
            end else begin
                o_cout = o_is_max;
                o_next = o_is_max ? '0 : (i_digit + 1'b1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_stopwatch_core.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stopwatch_core
// Description : Multi-digit BCD stopwatch / countdown timer with prescaled
//               tick, preset load, clear, overflow and done pulses.
//               Optional lap capture port set enabled by LAP_CAPTURE_EN.
// Revision    : 1.0  initial release
// ============================================================================
module bcd_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start_stop,
    input  logic                        clear,
    input  logic                        mode_down,
    input  logic                        load,
    input  logic [BCD_W*NUM_DIGITS-1:0] load_value,
    output logic [BCD_W*NUM_DIGITS-1:0] digits,
    output logic                        running,
    output logic                        overflow,
    output logic                        done
`ifdef LAP_CAPTURE_EN
    ,
    input  logic                        lap,
    output logic [BCD_W*NUM_DIGITS-1:0] lap_digits,
    output logic                        lap_valid
`endif
);

    localparam int              c_W          = BCD_W * NUM_DIGITS;
    localparam int              c_PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PW-1:0] c_PRESC_LAST = c_PW'(TICK_DIV - 1);

    sw_state_t         r_state, w_state_nxt;
    logic [c_PW-1:0]   r_presc, w_presc_nxt;
    logic [c_W-1:0]    r_count, w_count_nxt;
    logic [c_W-1:0]    w_step_count;
    logic [c_W-1:0]    w_load_clamped;
    logic [NUM_DIGITS:0]   w_carry;
    logic [NUM_DIGITS-1:0] w_is_max;
    logic [NUM_DIGITS-1:0] w_is_zero;
    logic              w_tick;
    logic              w_start_zero;
    logic              r_overflow, w_ovf_nxt;
    logic              r_done, w_done_nxt;

    assign w_carry[0] = 1'b1;

    generate
        for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
            bcd_digit_cell u_cell (
                .i_digit   (r_count[i*BCD_W +: BCD_W]),
                .i_enable  (w_tick),
                .i_down    (mode_down),
                .i_cin     (w_carry[i]),
                .o_next    (w_step_count[i*BCD_W +: BCD_W]),
                .o_cout    (w_carry[i+1]),
                .o_is_max  (w_is_max[i]),
                .o_is_zero (w_is_zero[i])
            );
            assign w_load_clamped[i*BCD_W +: BCD_W] = clamp_bcd(load_value[i*BCD_W +: BCD_W]);
        end
    endgenerate

    assign w_tick = (r_state == RUNNING) && (r_presc == c_PRESC_LAST);

    // Zero-count start refusal looks at the value that will be in the count after a same-cycle load.
    assign w_start_zero = load ? (w_load_clamped == '0) : (&w_is_zero);

    always_comb begin
        w_state_nxt = r_state;
        w_presc_nxt = r_presc;
        w_count_nxt = r_count;
        w_ovf_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        if (clear) begin
            w_state_nxt = STOPPED;
            w_presc_nxt = '0;
            w_count_nxt = '0;
        end else begin
            if (load) begin
                w_count_nxt = w_load_clamped;
                w_presc_nxt = '0;
            end else begin
                if (r_state == RUNNING) begin
                    w_presc_nxt = w_tick ? '0 : (r_presc + 1'b1);
                end
                if (w_tick) begin
                    w_count_nxt = w_step_count;
                    w_ovf_nxt   = !mode_down && (&w_is_max);
                    // A borrow out of the top digit means we wrapped from zero, not finished.
                    w_done_nxt  = mode_down && !w_carry[NUM_DIGITS] && (w_step_count == '0);
                    if (w_done_nxt) begin
                        w_state_nxt = STOPPED;
                    end
                end
            end
            if (start_stop) begin
                if (r_state == RUNNING) begin
                    w_state_nxt = STOPPED;
                end else if (!(mode_down && w_start_zero)) begin
                    w_state_nxt = RUNNING;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= STOPPED;
            r_presc    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_ovf_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign digits   = r_count;
    assign running  = (r_state == RUNNING);
    assign overflow = r_overflow;
    assign done     = r_done;

`ifdef LAP_CAPTURE_EN
    logic [c_W-1:0] r_lap_digits;
    logic           r_lap_valid;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_lap_digits <= '0;
            r_lap_valid  <= 1'b0;
        end else if (lap) begin
            r_lap_digits <= r_count;
            r_lap_valid  <= 1'b1;
        end
    end

    assign lap_digits = r_lap_digits;
    assign lap_valid  = r_lap_valid;
`endif

endmodule
`default_nettype wire
